// File: rtl/i2c_lat_seq.sv
// Round-robin transaction sequencer in front of a Lattice-style I2C master
// register bus: expands byte reads/writes into TXD/CMD/SR/RXD accesses.
module i2c_lat_seq #(
  parameter int          NREQ     = 2,
  parameter logic [7:0]  REG_CMD  = 8'h41,
  parameter logic [7:0]  REG_TXD  = 8'h42,
  parameter logic [7:0]  REG_RXD  = 8'h43,
  parameter logic [7:0]  REG_SR   = 8'h44,
  parameter int          POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ-1:0]   req_rd,
  input  logic [NREQ*7-1:0] req_saddr,
  input  logic [NREQ*8-1:0] req_reg,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_vld,
  output logic              rsp_err,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic [7:0]        bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_stb,
  input  logic              bus_ack,
  input  logic [7:0]        bus_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(POLL_MAX + 1);

  localparam logic [7:0] C_STA  = 8'h80;
  localparam logic [7:0] C_STO  = 8'h40;
  localparam logic [7:0] C_RD   = 8'h20;
  localparam logic [7:0] C_WR   = 8'h10;
  localparam logic [7:0] C_NACK = 8'h08;

  typedef enum logic [3:0] {
    IDLE, ARB, TXD_WR, CMD_WR, SR_RD,
    SR_CHK, RXD_RD, STOP_WR, DONE
  } state_e;

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [1:0]      step_q, step_d;
  logic [CW-1:0]   poll_q, poll_d;
  logic [6:0]      saddr_q, saddr_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            rd_q, rd_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            trrdy_q, trrdy_d;
  logic            rxnack_q, rxnack_d;
  logic            gap_q, gap_d;

  logic [PW-1:0]   sel;
  logic            found;
  logic            acc_done;
  logic            last_rx;
  logic            last_wr;
  logic [7:0]      ph_txd;
  logic [7:0]      ph_cmd;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign last_rx = rd_q && (step_q == 2'd3);
  assign last_wr = !rd_q && (step_q == 2'd2);

  always_comb begin
    ph_txd = 8'h00;
    ph_cmd = 8'h00;
    case (step_q)
      2'd0: begin
        ph_txd = {saddr_q, 1'b0};
        ph_cmd = C_STA | C_WR;
      end
      2'd1: begin
        ph_txd = reg_q;
        ph_cmd = C_WR;
      end
      2'd2: begin
        ph_txd = rd_q ? {saddr_q, 1'b1} : wdata_q;
        ph_cmd = rd_q ? (C_STA | C_WR) : (C_WR | C_STO);
      end
      default: begin
        ph_cmd = C_RD | C_NACK | C_STO;
      end
    endcase
  end

  always_comb begin
    bus_stb   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 8'h00;
    bus_wdata = 8'h00;
    unique case (state_q)
      TXD_WR: begin
        bus_stb   = !gap_q;
        bus_we    = 1'b1;
        bus_addr  = REG_TXD;
        bus_wdata = ph_txd;
      end
      CMD_WR: begin
        bus_stb   = !gap_q;
        bus_we    = 1'b1;
        bus_addr  = REG_CMD;
        bus_wdata = ph_cmd;
      end
      STOP_WR: begin
        bus_stb   = !gap_q;
        bus_we    = 1'b1;
        bus_addr  = REG_CMD;
        bus_wdata = C_STO;
      end
      SR_RD: begin
        bus_stb  = !gap_q;
        bus_addr = REG_SR;
      end
      RXD_RD: begin
        bus_stb  = !gap_q;
        bus_addr = REG_RXD;
      end
      default: ;
    endcase
  end

  assign acc_done = bus_stb && bus_ack;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    step_d   = step_q;
    poll_d   = poll_q;
    saddr_d  = saddr_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    trrdy_d  = trrdy_q;
    rxnack_d = rxnack_q;
    // force one idle strobe cycle after every completed access
    gap_d    = acc_done;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = sel;
          saddr_d = req_saddr[int'(sel)*7 +: 7];
          reg_d   = req_reg[int'(sel)*8 +: 8];
          wdata_d = req_wdata[int'(sel)*8 +: 8];
          rd_d    = req_rd[sel];
          if (int'(sel) == NREQ - 1) ptr_d = '0;
          else                       ptr_d = sel + 1'b1;
          state_d = ARB;
        end
      end
      ARB: begin
        step_d  = 2'd0;
        poll_d  = '0;
        err_d   = 1'b0;
        rdata_d = 8'h00;
        state_d = TXD_WR;
      end
      TXD_WR: if (acc_done) state_d = CMD_WR;
      CMD_WR: if (acc_done) state_d = SR_RD;
      SR_RD: begin
        if (acc_done) begin
          trrdy_d  = bus_rdata[2];
          rxnack_d = bus_rdata[5];
          if (poll_q != '1) poll_d = poll_q + 1'b1;
          state_d  = SR_CHK;
        end
      end
      SR_CHK: begin
        if (trrdy_q) begin
          if (!last_rx && rxnack_q) begin
            err_d   = 1'b1;
            state_d = last_wr ? DONE : STOP_WR;
          end else if (last_wr) begin
            state_d = DONE;
          end else if (last_rx) begin
            state_d = RXD_RD;
          end else begin
            step_d  = step_q + 2'd1;
            poll_d  = '0;
            // the read data phase has no transmit byte
            if (rd_q && step_q == 2'd2) state_d = CMD_WR;
            else                        state_d = TXD_WR;
          end
        end else if (poll_q >= CW'(POLL_MAX)) begin
          err_d   = 1'b1;
          state_d = STOP_WR;
        end else begin
          state_d = SR_RD;
        end
      end
      RXD_RD: begin
        if (acc_done) begin
          rdata_d = bus_rdata;
          state_d = DONE;
        end
      end
      STOP_WR: if (acc_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      step_q   <= '0;
      poll_q   <= '0;
      saddr_q  <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      trrdy_q  <= 1'b0;
      rxnack_q <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      step_q   <= step_d;
      poll_q   <= poll_d;
      saddr_q  <= saddr_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      trrdy_q  <= trrdy_d;
      rxnack_q <= rxnack_d;
      gap_q    <= gap_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign req_ack   = (state_q == ARB) ? (NREQ'(1) << win_q) : '0;
  assign rsp_vld   = (state_q == DONE) ? (NREQ'(1) << win_q) : '0;
  assign rsp_err   = (state_q == DONE) && err_q;
  assign rsp_rdata = (state_q == DONE) ? rdata_q : 8'h00;

endmodule

// File: tb/tb_i2c_lat_seq.sv
// Bench for i2c_lat_seq: register-bus slave model plus a transaction-level
// reference of the expected access list and response.
module tb_i2c_lat_seq;
  localparam int NREQ = 2;
  localparam int PM   = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NREQ-1:0]   req_vld = '0;
  logic [NREQ-1:0]   req_rd = '0;
  logic [NREQ*7-1:0] req_saddr = '0;
  logic [NREQ*8-1:0] req_reg = '0;
  logic [NREQ*8-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   rsp_vld;
  logic              rsp_err;
  logic [7:0]        rsp_rdata;
  logic              busy;
  logic [7:0]        bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_we;
  logic              bus_stb;
  logic              bus_ack = 1'b0;
  logic [7:0]        bus_rdata = '0;

  int checks = 0;
  int failures = 0;
  int exp_ptr = 0;

  i2c_lat_seq #(.NREQ(NREQ), .POLL_MAX(PM)) dut (
    .clk(clk), .resetn(resetn),
    .req_vld(req_vld), .req_rd(req_rd),
    .req_saddr(req_saddr), .req_reg(req_reg),
    .req_wdata(req_wdata), .req_ack(req_ack),
    .rsp_vld(rsp_vld), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_stb(bus_stb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // slave behaviour knobs
  bit          nack_en;
  int          nack_ph;
  bit          never_rdy;
  int          busy_n;
  logic [7:0]  rxd_val;
  int          cmd_cnt;
  int          sr_polls;
  logic [16:0] log_q[$];
  int          prot_err;
  bit          in_acc;
  logic [16:0] cur;
  int          wcnt;

  always @(negedge clk) begin
    logic [16:0] now;
    now = {bus_we, bus_addr, bus_we ? bus_wdata : 8'h00};
    if (!resetn) begin
      bus_ack = 1'b0;
      in_acc  = 1'b0;
    end else if (bus_ack) begin
      bus_ack = 1'b0;
      if (bus_stb) prot_err++;
    end else if (bus_stb) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        cur    = now;
        wcnt   = int'($urandom_range(0, 2));
      end else if (now !== cur) begin
        prot_err++;
      end
      if (wcnt == 0) begin
        bus_ack = 1'b1;
        in_acc  = 1'b0;
        log_q.push_back(cur);
        bus_rdata = 8'h00;
        if (cur[16] && cur[15:8] == 8'h41) begin
          cmd_cnt++;
          sr_polls = 0;
        end else if (!cur[16] && cur[15:8] == 8'h44) begin
          if (never_rdy) bus_rdata = 8'h00;
          else if (sr_polls < busy_n) sr_polls++;
          else if (nack_en && cmd_cnt - 1 == nack_ph)
            bus_rdata = 8'h24;
          else
            bus_rdata = 8'h04;
        end else if (!cur[16] && cur[15:8] == 8'h43) begin
          bus_rdata = rxd_val;
        end
      end else begin
        wcnt--;
      end
    end
  end

  logic [16:0] exp_q[$];
  bit          exp_err;
  logic [7:0]  exp_rdata;

  task automatic model(input bit rd, input logic [6:0] sa,
                       input logic [7:0] rg, input logic [7:0] wd,
                       input int nph, input bit nev, input int bn,
                       input logic [7:0] rx);
    logic [7:0] txd[4];
    logic [7:0] cmd[4];
    int np;
    exp_q.delete();
    exp_err   = 1'b0;
    exp_rdata = 8'h00;
    txd[0] = {sa, 1'b0}; cmd[0] = 8'h90;
    txd[1] = rg;         cmd[1] = 8'h10;
    if (rd) begin
      txd[2] = {sa, 1'b1}; cmd[2] = 8'h90;
      txd[3] = 8'h00;      cmd[3] = 8'h68;
      np = 4;
    end else begin
      txd[2] = wd; cmd[2] = 8'h50;
      txd[3] = 8'h00; cmd[3] = 8'h00;
      np = 3;
    end
    for (int p = 0; p < np; p++) begin
      if (!(rd && p == 3)) exp_q.push_back({1'b1, 8'h42, txd[p]});
      exp_q.push_back({1'b1, 8'h41, cmd[p]});
      if (nev) begin
        repeat (PM) exp_q.push_back({1'b0, 8'h44, 8'h00});
        exp_q.push_back({1'b1, 8'h41, 8'h40});
        exp_err = 1'b1;
        return;
      end
      repeat (bn + 1) exp_q.push_back({1'b0, 8'h44, 8'h00});
      if (p == nph && !(rd && p == 3)) begin
        if (!cmd[p][6]) exp_q.push_back({1'b1, 8'h41, 8'h40});
        exp_err = 1'b1;
        return;
      end
    end
    if (rd) begin
      exp_q.push_back({1'b0, 8'h43, 8'h00});
      exp_rdata = rx;
    end
  endtask

  task automatic set_req(input int idx, input bit rd, input logic [6:0] sa,
                         input logic [7:0] rg, input logic [7:0] wd);
    req_rd[idx]            = rd;
    req_saddr[idx*7 +: 7]  = sa;
    req_reg[idx*8 +: 8]    = rg;
    req_wdata[idx*8 +: 8]  = wd;
  endtask

  task automatic slave_cfg(input int nph, input bit nev, input int bn,
                           input logic [7:0] rx);
    nack_en   = (nph >= 0);
    nack_ph   = nph;
    never_rdy = nev;
    busy_n    = bn;
    rxd_val   = rx;
    cmd_cnt   = 0;
    sr_polls  = 0;
    prot_err  = 0;
    log_q.delete();
  endtask

  task automatic run_txn(input int idx, input bit rd, input logic [6:0] sa,
                         input logic [7:0] rg, input logic [7:0] wd,
                         input int nph, input bit nev, input int bn,
                         input logic [7:0] rx, input string nm);
    logic [NREQ-1:0] oh;
    int t;
    int bad;
    oh = NREQ'(1) << idx;
    slave_cfg(nph, nev, bn, rx);
    model(rd, sa, rg, wd, nph, nev, bn, rx);
    set_req(idx, rd, sa, rg, wd);
    req_vld[idx] = 1'b1;
    t = 0;
    while (!(|req_ack) && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (req_ack !== oh || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s ack got=%b/busy%b exp=%b/busy1", nm, req_ack, busy, oh);
    end
    req_vld[idx] = 1'b0;
    exp_ptr = (idx + 1) % NREQ;
    t = 0;
    while (!(|rsp_vld) && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (rsp_vld !== oh) begin
      failures++;
      $display("FAIL %s rsp_vld got=%b exp=%b", nm, rsp_vld, oh);
    end
    checks++;
    if (rsp_err !== exp_err) begin
      failures++;
      $display("FAIL %s rsp_err got=%b exp=%b", nm, rsp_err, exp_err);
    end
    checks++;
    if (rsp_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL %s rdata got=%h exp=%h", nm, rsp_rdata, exp_rdata);
    end
    @(negedge clk);
    bad = -1;
    if (log_q.size() != exp_q.size()) bad = log_q.size();
    else
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && log_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s bus_seq got_len=%0d exp_len=%0d first_bad=%0d",
               nm, log_q.size(), exp_q.size(), bad);
    end
    checks++;
    if (prot_err !== 0) begin
      failures++;
      $display("FAIL %s bus_protocol got=%0d exp=0", nm, prot_err);
    end
  endtask

  task automatic check_idle_outs(input string nm);
    logic [39:0] v;
    v = {req_ack, rsp_vld, rsp_err, rsp_rdata, busy,
         bus_addr, bus_wdata, bus_we, bus_stb};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL %s outputs got=%h exp=0", nm, v);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outs("reset_hold");
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outs("reset_release");
    exp_ptr = 0;
  endtask

  task automatic test_write();
    run_txn(0, 0, 7'h50, 8'h10, 8'hA5, -1, 0,
            int'($urandom_range(0, 3)), 8'h00, "write");
  endtask

  task automatic test_read();
    run_txn(1, 1, 7'h50, 8'h20, 8'h00, -1, 0,
            int'($urandom_range(0, 3)), 8'h3C, "read");
  endtask

  task automatic test_nack();
    run_txn(0, 0, 7'h50, 8'h11, 8'h22, 0, 0,
            int'($urandom_range(0, 3)), 8'h00, "nack_addr");
  endtask

  task automatic test_timeout();
    run_txn(1, 1, 7'h33, 8'h44, 8'h00, -1, 1, 0, 8'h00, "timeout");
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int idx;
      bit rd;
      int nph;
      bit nev;
      idx = int'($urandom_range(0, NREQ - 1));
      rd  = 1'($urandom);
      nph = int'($urandom_range(0, 4)) - 2;
      if (nph < -1) nph = -1;
      nev = ($urandom_range(0, 7) == 0);
      run_txn(idx, rd, 7'($urandom), 8'($urandom), 8'($urandom),
              nph, nev, int'($urandom_range(0, 3)), 8'($urandom),
              $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    int nrsp;
    int t;
    bit pend;
    int curw;
    logic [NREQ-1:0] oh;
    slave_cfg(-1, 0, 0, 8'h00);
    set_req(0, 0, 7'h21, 8'h01, 8'h5A);
    set_req(1, 0, 7'h22, 8'h02, 8'hC3);
    req_vld = 2'b11;
    nrsp = 0; t = 0; pend = 0; curw = 0;
    while (nrsp < 4 && t < 4000) begin
      @(negedge clk);
      t++;
      if (|req_ack) begin
        oh = NREQ'(1) << exp_ptr;
        checks++;
        if (req_ack !== oh || pend) begin
          failures++;
          $display("FAIL b2b_grant got=%b pend=%b exp=%b", req_ack, pend, oh);
        end
        pend = 1;
        curw = exp_ptr;
        exp_ptr = (exp_ptr + 1) % NREQ;
      end
      if (|rsp_vld) begin
        oh = NREQ'(1) << curw;
        checks++;
        if (rsp_vld !== oh || !pend || rsp_err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_rsp got=%b/err%b pend=%b exp=%b/err0",
                   rsp_vld, rsp_err, pend, oh);
        end
        pend = 0;
        nrsp++;
        if (nrsp == 4) req_vld = '0;
      end
    end
    req_vld = '0;
    checks++;
    if (nrsp != 4 || prot_err != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d/prot%0d exp=4/prot0", nrsp, prot_err);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t;
    slave_cfg(-1, 1, 0, 8'h00);
    set_req(0, 0, 7'h10, 8'h20, 8'h30);
    req_vld[0] = 1'b1;
    t = 0;
    while (!(|req_ack) && t < 50) begin @(negedge clk); t++; end
    req_vld = '0;
    exp_ptr = 1;
    t = 0;
    while (!(bus_stb && bus_addr == 8'h44) && t < 200) begin
      @(negedge clk); t++;
    end
    checks++;
    if (!(bus_stb && bus_addr == 8'h44)) begin
      failures++;
      $display("FAIL midreset_poll got=%h exp=44", bus_addr);
    end
    #2 resetn = 1'b0;
    #1 check_idle_outs("midreset_outs");
    req_vld = 2'b11;
    slave_cfg(-1, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    exp_ptr = 0;
    t = 0;
    while (!(|req_ack) && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (req_ack !== 2'b01) begin
      failures++;
      $display("FAIL midreset_grant got=%b exp=01", req_ack);
    end
    req_vld = '0;
    exp_ptr = 1;
    t = 0;
    while (!(|rsp_vld) && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (rsp_vld !== 2'b01 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_rsp got=%b/err%b exp=01/err0", rsp_vld, rsp_err);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    slave_cfg(-1, 0, 0, 8'h00);
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
